// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with held grants; ARB_TIMEOUT_EN adds forced rotation after MAX_HOLD cycles
module rr_arbiter8 #(
  parameter logic [2:0] RST_PTR  = 3'd0,
  parameter int         MAX_HOLD = 16,
  parameter int         CNT_W    = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] req_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_vld_o,
  output logic       timeout_o
);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e     state_q;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic [2:0] ptr_q;
  logic       to_q;
  logic [7:0] cand;
  logic [2:0] win;
  logic [2:0] j;
  logic       found;
  logic       held;
  logic       force_rot;
  logic       take;

  if (MAX_HOLD < 2 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter8: need MAX_HOLD >= 2 and 2**CNT_W > MAX_HOLD");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] cnt_q;
  assign force_rot = held && cnt_q == HOLD_LAST && found && en_i;
  // Hold counter: clears on each new grant, saturates at the rotation threshold
  always_ff @(posedge clk_i) begin
    if (!rst_ni || take) cnt_q <= '0;
    else if (held && cnt_q != HOLD_LAST) cnt_q <= cnt_q + 1'b1;
  end
`else
  assign force_rot = 1'b0;
`endif

  // Winner search from ptr, excluding the current owner so a release never re-grants the same cycle
  always_comb begin
    held  = state_q == GRANT && req_i[idx_q];
    cand  = (state_q == GRANT) ? req_i & ~gnt_q : req_i;
    found = 1'b0;
    win   = ptr_q;
    j     = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      j = ptr_q + 3'(k);
      if (cand[j]) begin
        found = 1'b1;
        win   = j;
      end
    end
    take = en_i && found && (!held || force_rot);
  end

  // Grant FSM: new grant on take, hold while owner requests, otherwise fall back to idle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= RST_PTR;
      to_q    <= 1'b0;
    end else begin
      to_q <= force_rot;
      if (take) begin
        state_q <= GRANT;
        idx_q   <= win;
        gnt_q   <= 8'd1 << win;
        ptr_q   <= win + 3'd1;
      end else if (!held) begin
        state_q <= IDLE;
        gnt_q   <= '0;
        idx_q   <= '0;
      end
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign gnt_vld_o = state_q == GRANT;
  assign timeout_o = to_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vector table plus randomized run against a behavioural round-robin model
module tb_rr_arbiter8;
`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter8 #(.RST_PTR(3'd0), .MAX_HOLD(MH), .CNT_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req),
    .gnt_o(gnt), .gnt_idx_o(gnt_idx), .gnt_vld_o(gnt_vld), .timeout_o(timeout)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;
  int   m_own = -1;
  int   m_ptr = 0;
  int   m_cnt = 0;
  logic m_to = 1'b0;

  function automatic void add(logic r, logic e, logic [7:0] q, logic [7:0] g, logic [2:0] i, logic t);
    tbl.push_back('{r, e, q, g, i, t});
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: owner index (-1 idle), pointer as integer, winner by modular scan
  function automatic void model_step(logic r, logic e, logic [7:0] q);
    int  w;
    bit  hold_now;
    bit  frc;
    logic [7:0] avail;
    if (!r) begin
      m_own = -1;
      m_ptr = 0;
      m_cnt = 0;
      m_to  = 1'b0;
      return;
    end
    hold_now = m_own >= 0 && q[m_own];
    avail = q;
    if (m_own >= 0) avail[m_own] = 1'b0;
    w = -1;
    for (int k = 0; k < 8; k++)
      if (w < 0 && avail[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
    frc = 0;
`ifdef ARB_TIMEOUT_EN
    frc = hold_now && m_cnt == MH - 1 && w >= 0 && e;
`endif
    m_to = frc;
    if ((!hold_now || frc) && e && w >= 0) begin
      m_own = w;
      m_ptr = (w + 1) % 8;
      m_cnt = 0;
    end else if (!hold_now) begin
      m_own = -1;
    end else if (m_cnt < MH - 1) begin
      m_cnt++;
    end
  endfunction

  task automatic cyc(logic r, logic e, logic [7:0] q);
    rst_n = r;
    en = e;
    req = q;
    model_step(r, e, q);
    @(posedge clk);
    #1;
    chk("vld_vs_gnt", {7'd0, gnt_vld}, {7'd0, |gnt});
    chk("gnt_decode", gnt, gnt_vld ? 8'd1 << gnt_idx : 8'd0);
  endtask

  initial begin
    logic [7:0] q;
    logic [7:0] m_gnt;
    add(0, 1, 8'hFF, 8'h00, 0, 0);
    add(0, 1, 8'hFF, 8'h00, 0, 0);
    add(1, 1, 8'hFF, 8'h01, 0, 0);
    for (int i = 1; i < 8; i++) begin
      q = 8'hFF;
      q[i-1] = 1'b0;
      add(1, 1, q, 8'd1 << i, 3'(i), 0);
    end
    add(1, 1, 8'h7F, 8'h01, 0, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0);
    add(1, 1, 8'h20, 8'h20, 5, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0);
    add(1, 1, 8'h05, 8'h01, 0, 0);
    add(1, 1, 8'h04, 8'h04, 2, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0);
    add(1, 1, 8'h08, 8'h08, 3, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 8'h18, 8'h08, 3, 0);
    add(1, 0, 8'h10, 8'h00, 0, 0);
    add(1, 1, 8'h10, 8'h10, 4, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0);
    add(1, 1, 8'h20, 8'h20, 5, 0);
    add(0, 1, 8'h20, 8'h00, 0, 0);
    add(1, 1, 8'h21, 8'h01, 0, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0);
`ifdef ARB_TIMEOUT_EN
    add(0, 1, 8'h03, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 8'h03, 8'h01, 0, 0);
    add(1, 1, 8'h03, 8'h02, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 1, 8'h03, 8'h02, 1, 0);
    add(1, 1, 8'h03, 8'h01, 0, 1);
    add(1, 1, 8'h00, 8'h00, 0, 0);
`endif
    foreach (tbl[i]) begin
      cyc(tbl[i].rst_n, tbl[i].en, tbl[i].req);
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_idx", i), {5'd0, gnt_idx}, {5'd0, tbl[i].idx});
      chk($sformatf("tbl%0d_vld", i), {7'd0, gnt_vld}, {7'd0, tbl[i].gnt != 8'd0});
      chk($sformatf("tbl%0d_timeout", i), {7'd0, timeout}, {7'd0, tbl[i].to});
    end
    q = '0;
    for (int n = 0; n < 3000; n++) begin
      q = ($urandom_range(0, 19) == 0) ? 8'($urandom) : q ^ 8'($urandom & $urandom & $urandom);
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0, q);
      m_gnt = (m_own < 0) ? 8'd0 : 8'd1 << m_own;
      chk("rnd_gnt", gnt, m_gnt);
      chk("rnd_idx", {5'd0, gnt_idx}, (m_own < 0) ? 8'd0 : 8'(m_own));
      chk("rnd_vld", {7'd0, gnt_vld}, {7'd0, m_own >= 0});
      chk("rnd_timeout", {7'd0, timeout}, {7'd0, m_to});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
